// File: rtl/sa_result_collector_if.sv
// Bus bundle for the systolic-array result collector: array-side capture
// inputs plus the byte-stream output and FIFO status.
interface sa_result_collector_if;
    logic        ena;
    logic        in_valid;
    logic [15:0] data_in1;
    logic [15:0] data_in2;
    logic [15:0] data_in3;
    logic [15:0] data_in4;
    logic [15:0] data_in5;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic [2:0]  fifo_count;
    logic        overflow;

    // Collector side
    modport master (
        input  ena, in_valid, data_in1, data_in2, data_in3, data_in4, data_in5, out_ready,
        output out_data, out_valid, out_last, fifo_count, overflow
    );

    // Feeder / consumer side
    modport slave (
        output ena, in_valid, data_in1, data_in2, data_in3, data_in4, data_in5, out_ready,
        input  out_data, out_valid, out_last, fifo_count, overflow
    );
endinterface

// File: rtl/sa_result_collector.sv
// Systolic-array result collector: deskews the five column-skewed lanes into
// one 80-bit row per tagged vector, buffers rows in a 4-deep FIFO and streams
// them out as ten bytes each over a valid/ready handshake.
module sa_result_collector (
    input  logic                 clk,
    input  logic                 clear,
    sa_result_collector_if.master bus
);
    localparam int unsigned LANES      = 5;
    localparam int unsigned DW         = 16;
    localparam int unsigned ARRAY_LAT  = 5;
    localparam int unsigned SKEW       = 1;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned TAG_LEN    = ARRAY_LAT + (LANES - 1) * SKEW;
    localparam int unsigned ROW_W      = LANES * DW;
    localparam int unsigned BYTES      = ROW_W / 8;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned D1         = (LANES - 1) * SKEW;
    localparam int unsigned D2         = (LANES - 2) * SKEW;
    localparam int unsigned D3         = (LANES - 3) * SKEW;
    localparam int unsigned D4         = (LANES - 4) * SKEW;

    typedef enum logic [0:0] {IDLE, SEND} state_t;

    logic [TAG_LEN-1:0] r_tag;
    logic [DW-1:0]      r_l1 [D1];
    logic [DW-1:0]      r_l2 [D2];
    logic [DW-1:0]      r_l3 [D3];
    logic [DW-1:0]      r_l4 [D4];

    logic [ROW_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_out_valid;
    logic               r_out_last;
    logic [7:0]         r_out_data;

    logic [ROW_W-1:0]   w_row;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic [PTR_W-1:0]   w_rd_next;
    logic [CNT_W-1:0]   w_count_next;
    state_t             w_state_next;
    logic [IDX_W-1:0]   w_idx_next;
    logic [ROW_W-1:0]   w_head_next;
    logic               w_out_valid_next;
    logic               w_out_last_next;
    logic [7:0]         w_out_data_next;

    // Tag line and per-lane deskew delays, advancing only with the array
    always_ff @(posedge clk) begin
        if (!clear) begin
            r_tag <= '0;
            for (int i = 0; i < int'(D1); i++) r_l1[i] <= '0;
            for (int i = 0; i < int'(D2); i++) r_l2[i] <= '0;
            for (int i = 0; i < int'(D3); i++) r_l3[i] <= '0;
            for (int i = 0; i < int'(D4); i++) r_l4[i] <= '0;
        end else if (bus.ena) begin
            r_tag   <= {r_tag[TAG_LEN-2:0], bus.in_valid};
            r_l1[0] <= bus.data_in1;
            r_l2[0] <= bus.data_in2;
            r_l3[0] <= bus.data_in3;
            r_l4[0] <= bus.data_in4;
            for (int i = 1; i < int'(D1); i++) r_l1[i] <= r_l1[i-1];
            for (int i = 1; i < int'(D2); i++) r_l2[i] <= r_l2[i-1];
            for (int i = 1; i < int'(D3); i++) r_l3[i] <= r_l3[i-1];
            for (int i = 1; i < int'(D4); i++) r_l4[i] <= r_l4[i-1];
        end
    end

    // Row assembly, FIFO push/pop decisions and next head row
    always_comb begin
        w_row        = {bus.data_in5, r_l4[D4-1], r_l3[D3-1], r_l2[D2-1], r_l1[D1-1]};
        w_push_req   = bus.ena && r_tag[TAG_LEN-1];
        w_pop        = (r_state == SEND) && bus.out_ready && (r_idx == IDX_W'(BYTES - 1));
        w_push       = w_push_req && ((r_count != CNT_W'(FIFO_DEPTH)) || w_pop);
        w_rd_next    = w_pop ? PTR_W'(r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
        w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        // A row written this edge into the slot that becomes head is not yet in memory
        w_head_next  = (w_push && (r_wr_ptr == w_rd_next)) ? w_row : r_mem[w_rd_next];
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (!clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= PTR_W'(r_wr_ptr + PTR_W'(1));
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            if (w_push_req && !w_push) r_overflow <= 1'b1;
        end
    end

    // Row storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (clear && w_push) r_mem[r_wr_ptr] <= w_row;
    end

    // Serializer next state, byte index and registered output values
    always_comb begin
        w_state_next     = r_state;
        w_idx_next       = r_idx;
        w_out_valid_next = 1'b0;
        w_out_last_next  = 1'b0;
        w_out_data_next  = '0;
        case (r_state)
            IDLE: begin
                if ((r_count != '0) || w_push) w_state_next = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (r_idx == IDX_W'(BYTES - 1)) begin
                        w_idx_next = '0;
                        if (w_count_next == '0) w_state_next = IDLE;
                    end else begin
                        w_idx_next = IDX_W'(r_idx + IDX_W'(1));
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (w_state_next == SEND) begin
            w_out_valid_next = 1'b1;
            w_out_last_next  = (w_idx_next == IDX_W'(BYTES - 1));
            w_out_data_next  = w_head_next[{w_idx_next, 3'b000} +: 8];
        end
    end

    // Serializer state register and output registers
    always_ff @(posedge clk) begin
        if (!clear) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_out_valid <= w_out_valid_next;
            r_out_last  <= w_out_last_next;
            r_out_data  <= w_out_data_next;
        end
    end

    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_last   = r_out_last;
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_sa_result_collector.sv
// Bench for sa_result_collector: a feeder emulates the skewed array lanes,
// expected bytes are queued at issue time and a monitor checks every accepted byte.
module tb_sa_result_collector;
    logic clk = 1'b0;
    logic clear;

    always #5 clk = ~clk;

    sa_result_collector_if bus ();

    sa_result_collector dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q [$];
    int         vid [0:1023];
    int         ecnt  = 0;
    int         rmode = 0;
    logic       rtog  = 1'b0;
    logic       st_pend = 1'b0;
    logic [8:0] st_prev = '0;
    int         peak = 0;

    // Single-row bytes for lanes 1101,2202,3303,4404,5505
    logic [7:0] k_row0 [10] = '{8'h01, 8'h11, 8'h02, 8'h22, 8'h03,
                                8'h33, 8'h04, 8'h44, 8'h05, 8'h55};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lane_val(input int id, input int j);
        return 16'(16'h1100 * j + j) ^ 16'(id * 16'h0840);
    endfunction

    task automatic push_const();
        for (int i = 0; i < 10; i++) exp_q.push_back({(i == 9), k_row0[i]});
    endtask

    task automatic push_row(input int id);
        for (int j = 1; j <= 5; j++) begin
            logic [15:0] v;
            v = lane_val(id, j);
            exp_q.push_back({1'b0, v[7:0]});
            exp_q.push_back({(j == 5), v[15:8]});
        end
    endtask

    task automatic set_lane(input int j, input logic [15:0] v);
        case (j)
            1: bus.data_in1 = v;
            2: bus.data_in2 = v;
            3: bus.data_in3 = v;
            4: bus.data_in4 = v;
            default: bus.data_in5 = v;
        endcase
    endtask

    // One cycle of feeder + consumer stimulus; lane j carries the vector issued 4+j array steps ago
    task automatic drive_cycle(input bit en, input bit iv, input int id);
        case (rmode)
            0: bus.out_ready = 1'b1;
            1: begin rtog = ~rtog; bus.out_ready = rtog; end
            default: bus.out_ready = 1'b0;
        endcase
        bus.ena = en;
        if (en) begin
            vid[ecnt]    = iv ? id : -1;
            bus.in_valid = iv;
            for (int j = 1; j <= 5; j++) begin
                int k;
                logic [15:0] v;
                k = ecnt - 4 - j;
                v = 16'h0000;
                if (k >= 0) begin
                    if (vid[k] >= 0) v = lane_val(vid[k], j);
                end
                set_lane(j, v);
            end
            ecnt++;
        end else begin
            bus.in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            drive_cycle(1'b1, 1'b0, 0);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        repeat (3) drive_cycle(1'b1, 1'b0, 0);
    endtask

    // Monitor: compare every accepted byte, and check stalled bytes stay put
    always @(negedge clk) begin
        if (clear) begin
            if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
            if (st_pend) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_byte", 32'({bus.out_last, bus.out_data}), 32'(st_prev));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h expected=none",
                             {bus.out_last, bus.out_data});
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("byte", 32'({bus.out_last, bus.out_data}), 32'(e));
                end
            end
            st_pend = bus.out_valid && !bus.out_ready;
            st_prev = {bus.out_last, bus.out_data};
        end else begin
            st_pend = 1'b0;
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) vid[i] = -1;
        clear         = 1'b0;
        bus.ena       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_in1  = '0;
        bus.data_in2  = '0;
        bus.data_in3  = '0;
        bus.data_in4  = '0;
        bus.data_in5  = '0;
        bus.out_ready = 1'b0;

        // Reset: two cycles low, then idle
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_last",  32'(bus.out_last),  32'd0);
        chk("rst_data",  32'(bus.out_data),  32'd0);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_ovf",   32'(bus.overflow),  32'd0);
        clear = 1'b1;
        rmode = 0;
        repeat (5) drive_cycle(1'b1, 1'b0, 0);
        chk("idle_valid", 32'(bus.out_valid), 32'd0);

        // Single row: first byte exactly 10 cycles after in_valid
        push_const();
        drive_cycle(1'b1, 1'b1, 0);
        repeat (8) drive_cycle(1'b1, 1'b0, 0);
        chk("single_lat_early", 32'(bus.out_valid), 32'd0);
        drive_cycle(1'b1, 1'b0, 0);
        chk("single_lat_first", 32'(bus.out_valid), 32'd1);
        chk("single_first_byte", 32'(bus.out_data), 32'h01);
        drain("single_drain", 40);

        // Back-pressure with alternating ready
        rmode = 1;
        push_const();
        drive_cycle(1'b1, 1'b1, 0);
        drain("bp_drain", 80);
        rmode = 0;

        // Streaming: four back-to-back vectors
        peak = 0;
        for (int v = 2; v <= 5; v++) begin
            push_row(v);
            drive_cycle(1'b1, 1'b1, v);
        end
        drain("stream_drain", 100);
        chk("stream_peak", 32'(peak), 32'd4);
        chk("stream_ovf", 32'(bus.overflow), 32'd0);

        // Overflow: ready held low, five vectors; the fifth row is dropped
        rmode = 2;
        for (int v = 6; v <= 10; v++) begin
            if (v < 10) push_row(v);
            drive_cycle(1'b1, 1'b1, v);
        end
        repeat (12) drive_cycle(1'b1, 1'b0, 0);
        chk("ovf_count", 32'(bus.fifo_count), 32'd4);
        chk("ovf_flag",  32'(bus.overflow),   32'd1);
        rmode = 0;
        drain("ovf_drain", 100);
        chk("ovf_count_empty", 32'(bus.fifo_count), 32'd0);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Reset clears the sticky flag
        clear = 1'b0;
        repeat (2) drive_cycle(1'b1, 1'b0, 0);
        clear = 1'b1;
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);

        // ena stall of three cycles delays the row by three cycles
        push_row(11);
        drive_cycle(1'b1, 1'b1, 11);
        repeat (2) drive_cycle(1'b1, 1'b0, 0);
        repeat (3) drive_cycle(1'b0, 1'b0, 0);
        repeat (6) drive_cycle(1'b1, 1'b0, 0);
        chk("stall_lat_early", 32'(bus.out_valid), 32'd0);
        drive_cycle(1'b1, 1'b0, 0);
        chk("stall_lat_first", 32'(bus.out_valid), 32'd1);
        drain("stall_drain", 40);

        // Mid-row reset discards the in-flight vector
        drive_cycle(1'b1, 1'b1, 12);
        repeat (5) drive_cycle(1'b1, 1'b0, 0);
        clear = 1'b0;
        repeat (2) drive_cycle(1'b1, 1'b0, 0);
        chk("mid_rst_valid", 32'(bus.out_valid),  32'd0);
        chk("mid_rst_last",  32'(bus.out_last),   32'd0);
        chk("mid_rst_data",  32'(bus.out_data),   32'd0);
        chk("mid_rst_count", 32'(bus.fifo_count), 32'd0);
        clear = 1'b1;
        repeat (20) drive_cycle(1'b1, 1'b0, 0);
        chk("mid_rst_no_row", 32'(bus.out_valid),  32'd0);
        chk("mid_rst_empty",  32'(bus.fifo_count), 32'd0);
        chk("queue_empty",    32'(exp_q.size()),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
